// File: rtl/gf13_pkg.sv
// rtl/gf13_pkg.sv - GF(2^13) constants, FSM encoding and elaboration-time field helpers
package gf13_pkg;
   localparam int          GF_M    = 13;
   localparam int          GF_N    = 8191;
   localparam logic [12:0] GF_POLY = 13'h001B;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_FIN    = 2'd2
   } gf_state_t;

   function automatic logic [12:0] gf_mul(input logic [12:0] a, input logic [12:0] b);
      logic [12:0] acc;
      logic [12:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < GF_M; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[12] ? ((sh << 1) ^ GF_POLY) : (sh << 1);
      end
      return acc;
   endfunction

   // Square-and-multiply keeps constant evaluation short for any exponent.
   function automatic logic [12:0] gf_alpha_pow(input int e);
      int          r;
      logic [12:0] acc;
      logic [12:0] base;
      r = e % GF_N;
      if (r < 0) r = r + GF_N;
      acc  = 13'd1;
      base = 13'd2;
      for (int i = 0; i < GF_M; i++) begin
         if (r[i]) acc = gf_mul(acc, base);
         base = gf_mul(base, base);
      end
      return acc;
   endfunction

   function automatic logic [4:0] gf_popcnt16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) n = n + 5'd1;
      end
      return n;
   endfunction
endpackage

// File: rtl/bch_chien_search_p16_if.sv
// rtl/bch_chien_search_p16_if.sv - Lambda input and error-mask output handshake bundle
interface bch_chien_search_p16_if #(parameter int T = 8);
   logic                  lam_valid;
   logic                  lam_ready;
   logic [13*(T+1)-1:0]   lam_in;
   logic [3:0]            lam_deg;
   logic                  err_valid;
   logic                  err_ready;
   logic [15:0]           err_mask;
   logic [8:0]            err_blk;
   logic                  done;
   logic [3:0]            err_cnt;
   logic                  fail;

   modport master (
      output lam_valid, lam_in, lam_deg, err_ready,
      input  lam_ready, err_valid, err_mask, err_blk, done, err_cnt, fail
   );

   modport slave (
      input  lam_valid, lam_in, lam_deg, err_ready,
      output lam_ready, err_valid, err_mask, err_blk, done, err_cnt, fail
   );
endinterface

// File: rtl/gf13_cmul_const.sv
// rtl/gf13_cmul_const.sv - combinational multiply by the constant alpha^E in GF(2^13)
module gf13_cmul_const
   import gf13_pkg::*;
#(
   parameter int E = 0
) (
   input  logic [12:0] i_x,
   output logic [12:0] o_y
);
   localparam logic [12:0] C = gf_alpha_pow(E);

   logic [12:0] w_col [GF_M];

   // Column i is C*alpha^i; the product is the XOR of columns selected by i_x.
   for (genvar i = 0; i < GF_M; i++) begin : g_col
      localparam logic [12:0] COL = gf_mul(C, 13'(1 << i));
      assign w_col[i] = i_x[i] ? COL : 13'd0;
   end

   always_comb begin
      o_y = '0;
      for (int i = 0; i < GF_M; i++) o_y = o_y ^ w_col[i];
   end
endmodule

// File: rtl/bch_chien_search_p16.sv
// rtl/bch_chien_search_p16.sv - 16-way parallel Chien search over GF(2^13)
// Define CHIEN_ERRCNT_CHECK_EN to enable root counting (err_cnt) and the degree check (fail).
module bch_chien_search_p16
   import gf13_pkg::*;
#(
   parameter int T     = 8,
   parameter int N_LEN = 8191,
   parameter int START = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   bch_chien_search_p16_if.slave bus
);
   localparam int          NBLK      = (N_LEN + 15) / 16;
   localparam int          LAST_W    = N_LEN - 16 * (NBLK - 1);
   localparam logic [8:0]  BLK_LAST  = 9'(NBLK - 1);
   localparam logic [15:0] LAST_KEEP = (LAST_W >= 16) ? 16'hFFFF : 16'((32'd1 << LAST_W) - 32'd1);

   gf_state_t   r_state;
   gf_state_t   w_state_nxt;
   logic [12:0] r_r    [T+1];
   logic [12:0] w_load [T+1];
   logic [12:0] w_upd  [T+1];
   logic [12:0] w_term [T+1][16];
   logic [12:0] w_syn;
   logic [15:0] w_mask;
   logic [15:0] r_mask;
   logic [8:0]  r_k;
   logic [8:0]  r_blk;
   logic        r_lam_ready;
   logic        r_err_valid;
   logic        r_done;
   logic        w_load_en;
   logic        w_step;
   logic        w_fin;
   logic        w_last;

   // R_j tracks Lambda_j*alpha^(j*(START+16k)); column p of the grid adds the j*p offset.
   for (genvar j = 0; j <= T; j++) begin : g_coef
      gf13_cmul_const #(.E(j * START)) u_load (.i_x(bus.lam_in[13*j +: 13]), .o_y(w_load[j]));
      gf13_cmul_const #(.E(16 * j))    u_upd  (.i_x(r_r[j]),                 .o_y(w_upd[j]));
      for (genvar p = 0; p < 16; p++) begin : g_eval
         gf13_cmul_const #(.E(j * p)) u_eval (.i_x(r_r[j]), .o_y(w_term[j][p]));
      end
   end

   assign w_last = (r_k == BLK_LAST);

   always_comb begin
      w_mask = '0;
      w_syn  = '0;
      for (int p = 0; p < 16; p++) begin
         w_syn = '0;
         for (int j = 0; j <= T; j++) w_syn = w_syn ^ w_term[j][p];
         w_mask[p] = (w_syn == 13'd0);
      end
      if (w_last) w_mask = w_mask & LAST_KEEP;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_en   = 1'b0;
      w_step      = 1'b0;
      w_fin       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.lam_valid && r_lam_ready) begin
               w_load_en   = 1'b1;
               w_state_nxt = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (!r_err_valid || bus.err_ready) begin
               w_step = 1'b1;
               if (w_last) w_state_nxt = ST_FIN;
            end
         end
         ST_FIN: begin
            if (bus.err_ready) begin
               w_fin       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_lam_ready <= 1'b0;
         r_err_valid <= 1'b0;
         r_mask      <= '0;
         r_blk       <= '0;
         r_k         <= '0;
         r_done      <= 1'b0;
         for (int j = 0; j <= T; j++) r_r[j] <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_lam_ready <= (w_state_nxt == ST_IDLE);
         r_done      <= w_fin;
         if (w_load_en) begin
            r_k <= '0;
            r_r <= w_load;
         end
         if (w_step) begin
            r_mask      <= w_mask;
            r_blk       <= r_k;
            r_err_valid <= 1'b1;
            r_k         <= r_k + 9'd1;
            r_r         <= w_upd;
         end
         if (w_fin) r_err_valid <= 1'b0;
      end
   end

   assign bus.lam_ready = r_lam_ready;
   assign bus.err_valid = r_err_valid;
   assign bus.err_mask  = r_mask;
   assign bus.err_blk   = r_blk;
   assign bus.done      = r_done;

`ifdef CHIEN_ERRCNT_CHECK_EN
   logic [3:0] r_err_cnt;
   logic [3:0] r_deg;
   logic       r_fail;
   logic [4:0] w_cnt_sum;

   assign w_cnt_sum = {1'b0, r_err_cnt} + gf_popcnt16(w_mask);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt <= '0;
         r_deg     <= '0;
         r_fail    <= 1'b0;
      end else begin
         if (w_load_en) begin
            r_err_cnt <= '0;
            r_deg     <= bus.lam_deg;
            r_fail    <= 1'b0;
         end
         if (w_step) r_err_cnt <= (w_cnt_sum > 5'd15) ? 4'd15 : w_cnt_sum[3:0];
         if (w_fin)  r_fail    <= (r_err_cnt != r_deg);
      end
   end

   assign bus.err_cnt = r_err_cnt;
   assign bus.fail    = r_fail;
`else
   assign bus.err_cnt = '0;
   assign bus.fail    = 1'b0;
`endif
endmodule

// File: tb/tb_bch_chien_search_p16.sv
// tb/tb_bch_chien_search_p16.sv - scoreboard bench for bch_chien_search_p16
module tb_bch_chien_search_p16;
   localparam int T    = 8;
   localparam int NBLK = 512;
   localparam int NPOS = 8191;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bch_chien_search_p16_if #(.T(T)) bus ();
   bch_chien_search_p16 #(.T(T), .N_LEN(NPOS), .START(1)) dut (.clk(clk), .rst(rst), .bus(bus));

   int          total = 0;
   int          bad   = 0;
   logic [12:0] lam [T+1];
   int          roots [$];
   logic [15:0] exp_q [$];
   int          exp_n;
   logic [3:0]  cur_deg;

   // Full product followed by reduction with x^13+x^4+x^3+x+1.
   function automatic logic [12:0] gmul(input logic [12:0] a, input logic [12:0] b);
      logic [25:0] p;
      p = '0;
      for (int i = 0; i < 13; i++) if (b[i]) p = p ^ (26'(a) << i);
      for (int i = 25; i >= 13; i--) if (p[i]) p = p ^ (26'h201B << (i - 13));
      return p[12:0];
   endfunction

   function automatic logic [12:0] gpow(input int e);
      logic [12:0] v;
      v = 13'd1;
      for (int i = 0; i < e; i++) v = gmul(v, 13'd2);
      return v;
   endfunction

   task automatic make_exp();
      logic [15:0] m [NBLK];
      for (int k = 0; k < NBLK; k++) m[k] = '0;
      foreach (roots[i]) m[(roots[i] - 1) / 16][(roots[i] - 1) % 16] = 1'b1;
      exp_q.delete();
      for (int k = 0; k < NBLK; k++) exp_q.push_back(m[k]);
      exp_n = (roots.size() > 15) ? 15 : roots.size();
   endtask

   task automatic make_lam();
      logic [12:0] nxt [T+1];
      logic [12:0] r;
      for (int j = 0; j <= T; j++) lam[j] = '0;
      lam[0] = 13'd1;
      foreach (roots[i]) begin
         r = gpow(roots[i] % NPOS);
         nxt[0] = gmul(lam[0], r);
         for (int j = 1; j <= T; j++) nxt[j] = lam[j-1] ^ gmul(lam[j], r);
         lam = nxt;
      end
   endtask

   task automatic load(input logic [3:0] deg, input bit hold);
      int n;
      @(negedge clk);
      bus.lam_valid = 1'b1;
      bus.lam_deg   = deg;
      for (int j = 0; j <= T; j++) bus.lam_in[13*j +: 13] = lam[j];
      cur_deg = deg;
      n = 0;
      while (bus.lam_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (bus.lam_ready !== 1'b1) begin
         bad++;
         $display("FAIL load_wait lam_ready=%b want 1", bus.lam_ready);
      end
      @(negedge clk);
      if (!hold) bus.lam_valid = 1'b0;
      total++;
      if (bus.err_valid !== 1'b0 || bus.lam_ready !== 1'b0) begin
         bad++;
         $display("FAIL lat_e0 err_valid=%b lam_ready=%b want 0 0", bus.err_valid, bus.lam_ready);
      end
   endtask

   task automatic drain(input bit rnd, input int abort_at);
      int          cyc;
      int          beats;
      bit          stalled;
      bit          saw_ready;
      bit          got_done;
      bit          rdy;
      logic [15:0] held_mask;
      logic [15:0] e;
      logic [8:0]  held_blk;
      logic [3:0]  xc;
      logic        xf;
      cyc = 0; beats = 0; stalled = 0; saw_ready = 0; got_done = 0;
      held_mask = '0; held_blk = '0;
      bus.err_ready = 1'b1;
      while (!got_done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            total++;
            if (bus.err_valid !== 1'b1 || bus.err_blk !== 9'd0) begin
               bad++;
               $display("FAIL lat_e1 err_valid=%b err_blk=%0d want 1 0", bus.err_valid, bus.err_blk);
            end
         end
         if (beats == abort_at) begin
            rst = 1'b1;
            #1;
            total++;
            if ({bus.lam_ready, bus.err_valid, bus.err_mask, bus.err_blk, bus.done, bus.err_cnt, bus.fail} !== 33'd0) begin
               bad++;
               $display("FAIL abort_reset rdy=%b vld=%b mask=%h blk=%0d done=%b cnt=%0d fail=%b want all 0",
                        bus.lam_ready, bus.err_valid, bus.err_mask, bus.err_blk, bus.done, bus.err_cnt, bus.fail);
            end
            exp_q.delete();
            return;
         end
         if (bus.done === 1'b1) begin
            got_done = 1'b1;
`ifdef CHIEN_ERRCNT_CHECK_EN
            xc = 4'(exp_n);
            xf = (4'(exp_n) != cur_deg);
`else
            xc = 4'd0;
            xf = 1'b0;
`endif
            total++;
            if (beats != NBLK || exp_q.size() != 0) begin
               bad++;
               $display("FAIL beat_count got=%0d left=%0d want %0d 0", beats, exp_q.size(), NBLK);
            end
            if (!rnd) begin
               total++;
               if (cyc != NBLK + 1) begin
                  bad++;
                  $display("FAIL done_latency got=%0d want %0d", cyc, NBLK + 1);
               end
            end
            total++;
            if (bus.err_cnt !== xc) begin
               bad++;
               $display("FAIL err_cnt got=%0d want %0d", bus.err_cnt, xc);
            end
            total++;
            if (bus.fail !== xf) begin
               bad++;
               $display("FAIL fail_flag got=%b want %b", bus.fail, xf);
            end
            total++;
            if (bus.lam_ready !== 1'b1 || saw_ready || bus.err_valid !== 1'b0) begin
               bad++;
               $display("FAIL done_state lam_ready=%b early_ready=%b err_valid=%b want 1 0 0",
                        bus.lam_ready, saw_ready, bus.err_valid);
            end
         end else begin
            if (bus.lam_ready !== 1'b0) saw_ready = 1'b1;
            if (stalled) begin
               total++;
               if (bus.err_valid !== 1'b1 || bus.err_mask !== held_mask || bus.err_blk !== held_blk) begin
                  bad++;
                  $display("FAIL stall_hold vld=%b mask=%h blk=%0d want 1 %h %0d",
                           bus.err_valid, bus.err_mask, bus.err_blk, held_mask, held_blk);
               end
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.err_ready = rdy;
            stalled   = (bus.err_valid === 1'b1) && !rdy;
            held_mask = bus.err_mask;
            held_blk  = bus.err_blk;
            if (bus.err_valid === 1'b1 && rdy) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL extra_beat blk=%0d mask=%h want none", bus.err_blk, bus.err_mask);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.err_mask !== e || bus.err_blk !== 9'(beats)) begin
                     bad++;
                     $display("FAIL beat mask=%h blk=%0d want %h %0d", bus.err_mask, bus.err_blk, e, beats);
                  end
               end
               beats++;
            end
         end
      end
      if (!got_done) begin
         total++;
         bad++;
         $display("FAIL done_timeout beats=%0d want done after %0d", beats, NBLK);
      end
   endtask

   task automatic set_single_root_lam();
      for (int j = 0; j <= T; j++) lam[j] = '0;
      lam[0] = 13'd1;
      lam[1] = gpow(NPOS - 5);
      roots.delete();
      roots.push_back(5);
   endtask

   task automatic set_three_roots();
      roots.delete();
      roots.push_back(1);
      roots.push_back(17);
      roots.push_back(8191);
      make_lam();
   endtask

   task automatic test_reset();
      bus.lam_valid = 1'b0;
      bus.lam_in    = '0;
      bus.lam_deg   = '0;
      bus.err_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.lam_ready !== 1'b0) begin bad++; $display("FAIL rst_lam_ready got=%b want 0", bus.lam_ready); end
      total++;
      if (bus.err_valid !== 1'b0) begin bad++; $display("FAIL rst_err_valid got=%b want 0", bus.err_valid); end
      total++;
      if (bus.err_mask !== 16'h0) begin bad++; $display("FAIL rst_err_mask got=%h want 0", bus.err_mask); end
      total++;
      if (bus.err_blk !== 9'd0) begin bad++; $display("FAIL rst_err_blk got=%0d want 0", bus.err_blk); end
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want 0", bus.done); end
      total++;
      if (bus.err_cnt !== 4'd0 || bus.fail !== 1'b0) begin
         bad++;
         $display("FAIL rst_cnt_fail got=%0d %b want 0 0", bus.err_cnt, bus.fail);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.lam_ready !== 1'b1) begin bad++; $display("FAIL rel_lam_ready got=%b want 1", bus.lam_ready); end
   endtask

   task automatic test_lambda_one();
      roots.delete();
      make_lam();
      make_exp();
      load(4'd0, 1'b0);
      drain(1'b0, -1);
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b want 0", bus.done); end
   endtask

   task automatic test_single_root();
      set_single_root_lam();
      make_exp();
      load(4'd1, 1'b0);
      drain(1'b0, -1);
   endtask

   task automatic test_three_roots();
      set_three_roots();
      make_exp();
      load(4'd3, 1'b0);
      drain(1'b0, -1);
   endtask

   task automatic test_backpressure();
      set_single_root_lam();
      make_exp();
      load(4'd1, 1'b0);
      drain(1'b1, -1);
   endtask

   task automatic test_back_to_back();
      set_three_roots();
      make_exp();
      load(4'd3, 1'b1);
      set_single_root_lam();
      for (int j = 0; j <= T; j++) bus.lam_in[13*j +: 13] = lam[j];
      bus.lam_deg = 4'd1;
      drain(1'b0, -1);
      cur_deg = 4'd1;
      make_exp();
      @(negedge clk);
      bus.lam_valid = 1'b0;
      total++;
      if (bus.lam_ready !== 1'b0 || bus.err_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_accept lam_ready=%b err_valid=%b want 0 0", bus.lam_ready, bus.err_valid);
      end
      drain(1'b0, -1);
   endtask

   task automatic test_reset_mid_search();
      set_three_roots();
      make_exp();
      load(4'd3, 1'b0);
      drain(1'b0, 100);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.lam_ready !== 1'b1) begin bad++; $display("FAIL post_abort_ready got=%b want 1", bus.lam_ready); end
      make_exp();
      load(4'd3, 1'b0);
      drain(1'b0, -1);
   endtask

   task automatic test_full_degree();
      int r;
      bit dup;
      roots.delete();
      while (roots.size() < T) begin
         r = int'($urandom_range(1, NPOS));
         dup = 1'b0;
         foreach (roots[i]) if (roots[i] == r) dup = 1'b1;
         if (!dup) roots.push_back(r);
      end
      make_lam();
      make_exp();
      load(4'(T), 1'b0);
      drain(1'b1, -1);
   endtask

   task automatic test_deg_overflow();
      roots.delete();
      make_lam();
      make_exp();
      load(4'd15, 1'b0);
      drain(1'b0, -1);
   endtask

   initial begin
      test_reset();
      test_lambda_one();
      test_single_root();
      test_three_roots();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_search();
      test_full_degree();
      test_deg_overflow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
